bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter FRAME_BITS, default 74, SHALL set the bit-times per frame (2 mod + 4 addr + 64 data + 4 CRC); legal range is 2..127.
REQ-002 Parameter GUARD_CYCLES, default 2, SHALL set the idle bit-times after each frame; legal range is 1..15.
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port req, input, 16 bits, SHALL carry per-node requests for the shared serial bus_out (bit n = node n+1); it is level-sensitive.
REQ-006 Port grant, output, 16 bits, SHALL be the registered one-hot bus ownership, or all-zero.
REQ-007 Port grant_id, output, 4 bits, SHALL give the index of the current or most recent owner.
REQ-008 Port bit_idx, output, 7 bits, SHALL give the index of the bit-time being driven in the frame.
REQ-009 Port bus_busy, output, 1 bit, SHALL be high while state is BUSY.
REQ-010 Port frame_start, output, 1 bit, SHALL be a one-cycle pulse on the first BUSY cycle.
REQ-011 Port frame_end, output, 1 bit, SHALL be a one-cycle pulse on the first GUARD cycle after a completed frame.
REQ-012 Port abort, output, 1 bit, SHALL be a one-cycle pulse on the first GUARD cycle after an aborted frame.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and GUARD.
REQ-014 IDLE: when req != 0 at an edge, the arbiter SHALL move to BUSY, load grant with the winner's one-hot, set grant_id to the winner, set bit_idx to 0, and set ptr to the winner.
REQ-015 IDLE: when req == 0 at an edge, the arbiter SHALL stay in IDLE with grant = 0.
REQ-016 Winner selection SHALL be round-robin: the first set req bit searching upward from ptr+1, mod 16 (wraps 15->0). The last owner is lowest priority.
REQ-017 Request-to-grant latency SHALL be 1 cycle from IDLE.
REQ-018 BUSY: bit_idx SHALL increment by 1 per cycle, from 0 to FRAME_BITS-1, with grant held constant.
REQ-019 BUSY, at the edge where bit_idx == FRAME_BITS-1: the arbiter SHALL go to GUARD, clear grant to 0, and assert frame_end for the next cycle.
REQ-020 BUSY abort: if req[grant_id] == 0 at any edge, the arbiter SHALL go to GUARD, clear grant, and assert abort (not frame_end) for the next cycle. Abort takes priority over completion on the same edge.
REQ-021 Changes on non-owner req bits during BUSY or GUARD SHALL be ignored; they are not latched, only sampled in IDLE.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles, counted by a guard counter, and then return to IDLE. grant stays 0 and bit_idx holds 0.
REQ-023 IDLE SHALL last at least one cycle between frames.
REQ-024 Grant-to-grant spacing for back-to-back requests SHALL be exactly FRAME_BITS + GUARD_CYCLES + 1 cycles.
REQ-025 grant_id SHALL hold the last owner through GUARD and IDLE.
REQ-026 grant SHALL never have more than one bit set, and SHALL be 0 outside BUSY.
REQ-027 bit_idx SHALL never exceed FRAME_BITS-1, and the counter SHALL not wrap within a frame.

Reset
REQ-028 While reset is high at an edge, the arbiter SHALL set state to IDLE, grant to 0, grant_id to 0, bit_idx to 0, bus_busy/frame_start/frame_end/abort to 0, the guard counter to 0, and ptr to 15, so that node 0 wins first.
REQ-029 Reset asserted mid-BUSY or mid-GUARD SHALL take priority over all transitions. No frame_end or abort pulse SHALL be generated for the truncated frame.
REQ-030 On the first edge after reset deasserts, the arbiter SHALL evaluate req exactly as in IDLE.

Verification
REQ-031 Reset, then req=16'h0001 held -> at edge+1, grant=16'h0001, grant_id=0, frame_start=1, bus_busy=1; frame_end pulses 74 cycles after the grant edge; next grant exactly 77 cycles after the first.
REQ-032 req=16'hFFFF held from reset -> grant_id sequence 0,1,2,...,15,0; each grant held for exactly 74 cycles; no two grant bits ever set.
REQ-033 ptr=3 (node 3 served), then req=16'h0009 -> next winner is node 0 (wraps past 4..15), then node 3.
REQ-034 Node 5 granted; deassert req[5] at bit_idx=10 -> next cycle grant=0, abort=1, frame_end=0; GUARD for 2 cycles; then IDLE.
REQ-035 Assert reset at bit_idx=40 of a frame -> next cycle all outputs 0 and state IDLE; no frame_end/abort pulse; first post-reset grant goes to the lowest set req bit.
REQ-036 Toggle req[7] during node 2's BUSY and GUARD -> no effect on grant or bit_idx; node 7 granted only if req[7]=1 when sampled in IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter for a shared serial bus (frame timing with guard gap)
module bus_arbiter #(
    parameter int FRAME_BITS   = 74,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  grant_id,
    output logic [6:0]  bit_idx,
    output logic        bus_busy,
    output logic        frame_start,
    output logic        frame_end,
    output logic        abort
);

    localparam logic [6:0] LAST_BIT   = 7'(FRAME_BITS - 1);
    localparam logic [3:0] LAST_GUARD = 4'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GUARD} state_t;

    state_t      state_q, state_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  grant_id_q, grant_id_d;
    logic [6:0]  bit_idx_q, bit_idx_d;
    logic [3:0]  guard_cnt_q, guard_cnt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_end_q, frame_end_d;
    logic        abort_q, abort_d;

    logic [3:0]  winner;
    logic [3:0]  cand;

    // Scan from farthest to nearest so the nearest requester above ptr wins; ptr itself is last.
    always_comb begin
        winner = ptr_q;
        cand   = ptr_q;
        for (int i = 16; i >= 1; i--) begin
            cand = ptr_q + 4'(i);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 16'd0;
            grant_id_q    <= 4'd0;
            bit_idx_q     <= 7'd0;
            guard_cnt_q   <= 4'd0;
            ptr_q         <= 4'd15;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            bit_idx_q     <= bit_idx_d;
            guard_cnt_q   <= guard_cnt_d;
            ptr_q         <= ptr_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            abort_q       <= abort_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        bit_idx_d     = bit_idx_q;
        guard_cnt_d   = guard_cnt_q;
        ptr_d         = ptr_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        abort_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = 16'd0;
                if (|req) begin
                    state_d       = ST_BUSY;
                    grant_d       = 16'd1 << winner;
                    grant_id_d    = winner;
                    ptr_d         = winner;
                    bit_idx_d     = 7'd0;
                    frame_start_d = 1'b1;
                end
            end
            ST_BUSY: begin
                // Owner dropping its request outranks normal completion on the same edge.
                if (!req[grant_id_q] || bit_idx_q == LAST_BIT) begin
                    state_d     = ST_GUARD;
                    grant_d     = 16'd0;
                    bit_idx_d   = 7'd0;
                    guard_cnt_d = 4'd0;
                    abort_d     = !req[grant_id_q];
                    frame_end_d = req[grant_id_q];
                end else begin
                    bit_idx_d = bit_idx_q + 7'd1;
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == LAST_GUARD) begin
                    state_d     = ST_IDLE;
                    guard_cnt_d = 4'd0;
                end else begin
                    guard_cnt_d = guard_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 16'd0;
            end
        endcase
    end

    always_comb begin
        grant       = grant_q;
        grant_id    = grant_id_q;
        bit_idx     = bit_idx_q;
        bus_busy    = (state_q == ST_BUSY);
        frame_start = frame_start_q;
        frame_end   = frame_end_q;
        abort       = abort_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (vector table, corner sequences, random vs model)
module tb_bus_arbiter;

    localparam int FB = 74;
    localparam int GC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req = 16'd0;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic [6:0]  bit_idx;
    logic        bus_busy, frame_start, frame_end, abort;

    bus_arbiter #(.FRAME_BITS(FB), .GUARD_CYCLES(GC)) dut (
        .clock(clock), .reset(reset), .req(req), .grant(grant), .grant_id(grant_id),
        .bit_idx(bit_idx), .bus_busy(bus_busy), .frame_start(frame_start),
        .frame_end(frame_end), .abort(abort)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    // Reference: owner (-1 = nobody), position in frame, guard cycles remaining, last owner.
    int m_owner = -1, m_pos = 0, m_guard = 0, m_last = 0, m_ptr = 15;
    bit m_fs = 0, m_fe = 0, m_ab = 0;

    typedef struct {
        bit          rst;
        logic [15:0] r;
        logic [15:0] g;
        int          id;
        bit          busy;
        bit          fs;
        bit          fe;
        bit          ab;
        int          bi;
    } vec_t;
    vec_t vt[14];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit rst, input logic [15:0] r);
        if (rst) begin
            m_owner = -1; m_pos = 0; m_guard = 0; m_last = 0; m_ptr = 15;
            m_fs = 0; m_fe = 0; m_ab = 0;
        end else begin
            m_fs = 0; m_fe = 0; m_ab = 0;
            if (m_owner >= 0) begin
                if (!r[m_owner] || m_pos == FB - 1) begin
                    m_ab = !r[m_owner];
                    m_fe = r[m_owner];
                    m_owner = -1; m_pos = 0; m_guard = GC;
                end else begin
                    m_pos++;
                end
            end else if (m_guard > 0) begin
                m_guard--;
            end else if (r != 16'd0) begin
                for (int k = 1; k <= 16; k++) begin
                    if (r[(m_ptr + k) % 16]) begin
                        m_owner = (m_ptr + k) % 16;
                        break;
                    end
                end
                m_last = m_owner; m_ptr = m_owner; m_pos = 0; m_fs = 1;
            end
        end
    endtask

    task automatic tick(input bit rst, input logic [15:0] r);
        @(negedge clock);
        reset = rst;
        req   = r;
        @(posedge clock);
        model_step(rst, r);
        cyc++;
        #1;
        check("grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
        check("grant_id", int'(grant_id), m_last);
        check("bit_idx", int'(bit_idx), m_pos);
        check("bus_busy", int'(bus_busy), (m_owner >= 0) ? 1 : 0);
        check("frame_start", int'(frame_start), int'(m_fs));
        check("frame_end", int'(frame_end), int'(m_fe));
        check("abort", int'(abort), int'(m_ab));
        check("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    endtask

    task automatic next_start(input logic [15:0] r);
        int n = 0;
        do begin
            tick(1'b0, r);
            n++;
        end while (!frame_start && n < 300);
        if (!frame_start) check("start_timeout", 0, 1);
    endtask

    initial begin
        int t0, n;
        logic [15:0] r;

        vt[0]  = '{1'b1, 16'hFFFF, 16'h0000,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[1]  = '{1'b0, 16'h0000, 16'h0000,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[2]  = '{1'b0, 16'h0000, 16'h0000,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[3]  = '{1'b0, 16'h0010, 16'h0010,  4, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vt[4]  = '{1'b0, 16'h0010, 16'h0010,  4, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[5]  = '{1'b0, 16'h0011, 16'h0010,  4, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vt[6]  = '{1'b0, 16'h0001, 16'h0000,  4, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vt[7]  = '{1'b0, 16'h0001, 16'h0000,  4, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[8]  = '{1'b0, 16'h0001, 16'h0000,  4, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[9]  = '{1'b0, 16'h0001, 16'h0001,  0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vt[10] = '{1'b1, 16'h0001, 16'h0000,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[11] = '{1'b0, 16'h8001, 16'h0001,  0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vt[12] = '{1'b1, 16'h0000, 16'h0000,  0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[13] = '{1'b0, 16'h8000, 16'h8000, 15, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        for (int i = 0; i < 14; i++) begin
            tick(vt[i].rst, vt[i].r);
            check($sformatf("vec%0d_grant", i), int'(grant), int'(vt[i].g));
            check($sformatf("vec%0d_id", i), int'(grant_id), vt[i].id);
            check($sformatf("vec%0d_busy", i), int'(bus_busy), int'(vt[i].busy));
            check($sformatf("vec%0d_pulses", i), int'({frame_start, frame_end, abort}),
                  int'({vt[i].fs, vt[i].fe, vt[i].ab}));
            check($sformatf("vec%0d_bit", i), int'(bit_idx), vt[i].bi);
        end

        // Single requester: frame length and grant-to-grant spacing.
        tick(1'b1, 16'h0);
        tick(1'b0, 16'h0001);
        check("a_grant", int'(grant), 1);
        check("a_fs", int'(frame_start), 1);
        t0 = cyc;
        n = 0;
        while (!frame_end && n < 200) begin tick(1'b0, 16'h0001); n++; end
        check("a_fe_latency", cyc - t0, FB);
        next_start(16'h0001);
        check("a_spacing", cyc - t0, FB + GC + 1);

        // All requesting: strict rotation, full frames.
        tick(1'b1, 16'h0);
        for (int k = 0; k < 17; k++) begin
            next_start(16'hFFFF);
            check("b_id", int'(grant_id), k % 16);
            t0 = cyc;
            n = 0;
            while (bus_busy && n < 200) begin tick(1'b0, 16'hFFFF); n++; end
            check("b_hold", cyc - t0, FB);
        end

        // Wrap past the top of the ring.
        tick(1'b1, 16'h0);
        tick(1'b0, 16'h0008);
        check("c_first", int'(grant_id), 3);
        next_start(16'h0009);
        check("c_wrap", int'(grant_id), 0);
        next_start(16'h0009);
        check("c_then3", int'(grant_id), 3);

        // Owner drops request mid-frame.
        tick(1'b1, 16'h0);
        tick(1'b0, 16'h0020);
        check("d_id", int'(grant_id), 5);
        n = 0;
        while (bit_idx != 7'd10 && n < 100) begin tick(1'b0, 16'h0020); n++; end
        tick(1'b0, 16'h0000);
        check("d_grant0", int'(grant), 0);
        check("d_abort", int'(abort), 1);
        check("d_no_fe", int'(frame_end), 0);
        tick(1'b0, 16'h0020);
        check("d_guard2", int'(grant), 0);
        tick(1'b0, 16'h0020);
        check("d_idle", int'(grant), 0);
        tick(1'b0, 16'h0020);
        check("d_regrant", int'(grant), 16'h0020);

        // Reset mid-frame, then non-owner toggling during busy/guard.
        tick(1'b1, 16'h0);
        tick(1'b0, 16'h0004);
        n = 0;
        while (bit_idx != 7'd40 && n < 100) begin
            tick(1'b0, 16'h0004 | 16'($urandom_range(0, 1) << 7));
            n++;
        end
        tick(1'b1, 16'h0004);
        check("e_rst_out", int'({grant, grant_id, bit_idx, bus_busy, frame_start, frame_end, abort}), 0);
        tick(1'b0, 16'h0014);
        check("e_lowest", int'(grant), 16'h0004);
        n = 0;
        while (bus_busy && n < 100) begin
            tick(1'b0, 16'h0004 | 16'($urandom_range(0, 1) << 7));
            check("e_hold", int'(grant), bus_busy ? 16'h0004 : 0);
            n++;
        end
        check("e_fe", int'(frame_end), 1);
        tick(1'b0, 16'h0080);
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);
        check("e_no7", int'(grant), 0);
        tick(1'b0, 16'h0080);
        check("e_grant7", int'(grant), 16'h0080);

        // Random traffic against the reference.
        r = 16'h0;
        tick(1'b1, r);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: r = 16'h0;
                    1: r = 16'd1 << $urandom_range(0, 15);
                    2: r = 16'($urandom);
                    default: r = r ^ (16'd1 << $urandom_range(0, 15));
                endcase
            end
            tick($urandom_range(0, 399) == 0, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
